coef_dequant_pipe: RTL and testbench
====================================

// Module: coef_dequant_pipe
// PURPOSE
// - Parametrised dequantiser between the coefficient stream decoder and the IDCT input buffer.
// - Per coefficient: scale x quant-table multiply, round, divide by 8, clamp to OUT_W.
// - Adds N selectable quant tables and a bypass mode.
// - Valid/ready backpressure replaces freeze signalling; no coefficient is ever lost or duplicated.
// PARAMETERS
// COEF_W      10  signed input coefficient width
// SCALE_W     6   unsigned quantiser scale width
// QUANT_W     7   unsigned quant-table entry width; 4 entries packed per RAM word
// OUT_W       12  signed output coefficient width
// NUM_TABLES  2   quant tables (power of 2, >=2); TSEL_W = $clog2(NUM_TABLES)
// PORTS
// i_clk           in   1          clock
// i_rst           in   1          asynchronous reset, active-high
// i_valid         in   1          input coefficient valid
// o_ready         out  1          input accepted when i_valid & o_ready
// i_coef          in   COEF_W     signed coefficient
// i_scale         in   SCALE_W    quantiser scale
// i_isDC          in   1          coefficient is DC (item 0)
// i_mode          in   2          0 standard, 1 full-uncompressed, 2 bypass, 3 reserved (=bypass)
// i_tblSel        in   TSEL_W     quant table used by this coefficient
// i_index         in   6          IDCT write index, passed through
// i_linearIndex   in   6          linear index; addresses the quant table
// i_blockNum      in   3          block number, passed through
// i_last          in   1          last coefficient of matrix, passed through
// i_quantWrt      in   1          quant-table write strobe
// i_quantTbl      in   TSEL_W     table written
// i_quantAdr      in   4          word address (entries 4*adr..4*adr+3)
// i_quantValue    in   4*QUANT_W  packed entries, entry k at bits [k*QUANT_W +: QUANT_W]
// o_valid         out  1          output coefficient valid
// i_ready         in   1          downstream accepts when o_valid & i_ready
// o_coef          out  OUT_W      dequantised signed coefficient
// o_index         out  6          pipelined i_index
// o_blockNum      out  3          pipelined i_blockNum
// o_last          out  1          pipelined i_last
// BEHAVIOUR
// - Pipeline stages: S0 (input register + RAM address), S1 (product), S2 (output register).
// - stall = o_valid & !i_ready; o_ready = !stall (combinational).
// - Every stage register, including the RAM read-address register, is enabled by !stall.
// - RAM data therefore stays aligned under any stall length; no quant-value backup register exists.
// - Latency: input accepted in cycle N -> o_valid in cycle N+2 when no stall. Throughput 1/cycle.
// - Bubbles (i_valid=0) propagate as valid=0; they do not block later data.
// - Outputs are stable while o_valid & !i_ready.
// - Factors by mode:
//   - standard AC: s=i_scale, q=T[tbl][lin]
//   - standard DC: s=8, q=T[tbl][0]
//   - full: s=16, q=1 (tables unused)
//   - bypass: o_coef = sign-extended i_coef, no rounding
// - Arithmetic: p = coef*s*q, exact signed; width COEF_W+SCALE_W+QUANT_W+2.
// - Output: y = (p+4) >>> 3 (arithmetic shift, floor).
// - Clamp: y to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
// - Quant RAM: registered-address read.
// - Simultaneous write and read of the same word returns the OLD word (read-first).
// - Table writes may occur while data flows; software only rewrites a table when it is unused.
// - Reset (async, any time):
//   - o_valid=0, o_coef=0, o_index=0, o_blockNum=0, o_last=0, all stage valids=0.
//   - In-flight coefficients are dropped; o_ready=1 after reset.
//   - Quant RAM contents are not reset.
// TESTING
// - Standard AC, T0[5]=16, coef=100, scale=10 -> o_coef=2000, 2 cycles after accept.
// - Rounding: coef=-1, scale=1, q=1 -> 0; coef=-5, scale=1, q=2 -> -1; coef=3, scale=1, q=1 -> 0.
// - Clamp: coef=511, scale=63, q=127 -> 2047; coef=-512, scale=63, q=127 -> -2048.
// - Modes:
//   - DC coef=-3, T1[0]=8, scale=40 -> -24 (scale ignored).
//   - Full mode coef=-7 -> -14.
//   - Bypass coef=-512 -> -512.
// - Backpressure: stream 64 coefs, i_ready random 50%, holds up to 10 cycles.
//   - Output sequence matches the model exactly; outputs stable while stalled.
// - Write T0 word 1 in the same cycle a linIdx=4 coefficient is accepted -> old entry used.
// - Next coefficient with linIdx=4 -> new entry used.
// - Assert i_rst mid-stream with 2 coefs in flight -> o_valid=0 immediately.
//   - After release, first output is the first coef accepted post-reset.

Source files
------------

// File: rtl/coef_dequant_pipe.sv
// Coefficient dequantiser: scale x quant-table multiply, round, /8, clamp to OUT_W.
// Three register stages (S0 input/RAM read, S1 product, S2 output), all held together on stall.
module coef_dequant_pipe #(
    parameter int COEF_W     = 10,
    parameter int SCALE_W    = 6,
    parameter int QUANT_W    = 7,
    parameter int OUT_W      = 12,
    parameter int NUM_TABLES = 2,
    localparam int TSEL_W    = $clog2(NUM_TABLES)
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_valid,
    output logic                      o_ready,
    input  logic signed [COEF_W-1:0]  i_coef,
    input  logic [SCALE_W-1:0]        i_scale,
    input  logic                      i_isDC,
    input  logic [1:0]                i_mode,
    input  logic [TSEL_W-1:0]         i_tblSel,
    input  logic [5:0]                i_index,
    input  logic [5:0]                i_linearIndex,
    input  logic [2:0]                i_blockNum,
    input  logic                      i_last,
    input  logic                      i_quantWrt,
    input  logic [TSEL_W-1:0]         i_quantTbl,
    input  logic [3:0]                i_quantAdr,
    input  logic [4*QUANT_W-1:0]      i_quantValue,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic signed [OUT_W-1:0]   o_coef,
    output logic [5:0]                o_index,
    output logic [2:0]                o_blockNum,
    output logic                      o_last
);
    localparam int PW = COEF_W + SCALE_W + QUANT_W + 2;
    localparam int QW = 4 * QUANT_W;
    localparam logic signed [PW-1:0] RND  = PW'(4);
    localparam logic signed [PW-1:0] MAXV = PW'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [PW-1:0] MINV = ~MAXV;

    logic stall;
    assign stall   = o_valid & ~i_ready;
    assign o_ready = ~stall;

    logic [QW-1:0] ram [2**(TSEL_W+4)];

    always_ff @(posedge i_clk) begin
        if (i_quantWrt) ram[{i_quantTbl, i_quantAdr}] <= i_quantValue;
    end

    // S0: registered inputs plus the read word (read-first against a same-cycle write)
    logic                     s0_valid, s0_dc, s0_last;
    logic signed [COEF_W-1:0] s0_coef;
    logic [SCALE_W-1:0]       s0_scale;
    logic [1:0]               s0_mode, s0_sel;
    logic [5:0]               s0_index;
    logic [2:0]               s0_blk;
    logic [QW-1:0]            s0_word;

    // S1: exact product
    logic                     s1_valid, s1_bypass, s1_last;
    logic signed [PW-1:0]     s1_prod;
    logic signed [COEF_W-1:0] s1_coef;
    logic [5:0]               s1_index;
    logic [2:0]               s1_blk;

    logic [SCALE_W-1:0]       s_fac;
    logic [QUANT_W-1:0]       q_fac;
    logic signed [SCALE_W:0]  s_sx;
    logic signed [QUANT_W:0]  q_sx;
    logic signed [PW-1:0]     prod;

    always_comb begin
        s_fac = s0_scale;
        q_fac = s0_word[s0_sel*QUANT_W +: QUANT_W];
        if (s0_mode == 2'd1) begin
            s_fac = SCALE_W'(16);
            q_fac = QUANT_W'(1);
        end else if (s0_dc) begin
            s_fac = SCALE_W'(8);
        end
        s_sx = {1'b0, s_fac};
        q_sx = {1'b0, q_fac};
        prod = PW'(s0_coef) * PW'(s_sx) * PW'(q_sx);
    end

    logic signed [PW-1:0]    shifted;
    logic signed [OUT_W-1:0] y;

    always_comb begin
        shifted = (s1_prod + RND) >>> 3;
        if (s1_bypass)           y = OUT_W'(s1_coef);
        else if (shifted > MAXV) y = MAXV[OUT_W-1:0];
        else if (shifted < MINV) y = MINV[OUT_W-1:0];
        else                     y = shifted[OUT_W-1:0];
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s0_valid <= 1'b0; s0_dc <= 1'b0; s0_last <= 1'b0; s0_coef <= '0;
            s0_scale <= '0; s0_mode <= '0; s0_sel <= '0; s0_index <= '0;
            s0_blk <= '0; s0_word <= '0;
            s1_valid <= 1'b0; s1_bypass <= 1'b0; s1_last <= 1'b0; s1_prod <= '0;
            s1_coef <= '0; s1_index <= '0; s1_blk <= '0;
            o_valid <= 1'b0; o_coef <= '0; o_index <= '0; o_blockNum <= '0; o_last <= 1'b0;
        end else if (!stall) begin
            s0_valid <= i_valid;
            s0_dc    <= i_isDC;
            s0_last  <= i_last;
            s0_coef  <= i_coef;
            s0_scale <= i_scale;
            s0_mode  <= i_mode;
            s0_sel   <= i_isDC ? 2'd0 : i_linearIndex[1:0];
            s0_index <= i_index;
            s0_blk   <= i_blockNum;
            s0_word  <= ram[{i_tblSel, i_isDC ? 4'd0 : i_linearIndex[5:2]}];

            s1_valid  <= s0_valid;
            s1_bypass <= s0_mode[1];
            s1_last   <= s0_last;
            s1_prod   <= prod;
            s1_coef   <= s0_coef;
            s1_index  <= s0_index;
            s1_blk    <= s0_blk;

            o_valid    <= s1_valid;
            o_coef     <= y;
            o_index    <= s1_index;
            o_blockNum <= s1_blk;
            o_last     <= s1_last;
        end
    end
endmodule

// File: tb/tb_coef_dequant_pipe.sv
// Scoreboard bench for coef_dequant_pipe: expected words queued at accept, checked at output.
module tb_coef_dequant_pipe;
    localparam int COEF_W = 10, SCALE_W = 6, QUANT_W = 7, OUT_W = 12, NUM_TABLES = 2;
    localparam int TSEL_W = 1;

    logic i_clk, i_rst, i_valid, o_ready, i_isDC, i_last, i_quantWrt, o_valid, i_ready, o_last;
    logic signed [COEF_W-1:0] i_coef;
    logic [SCALE_W-1:0] i_scale;
    logic [1:0] i_mode;
    logic [TSEL_W-1:0] i_tblSel, i_quantTbl;
    logic [5:0] i_index, i_linearIndex, o_index;
    logic [2:0] i_blockNum, o_blockNum;
    logic [3:0] i_quantAdr;
    logic [4*QUANT_W-1:0] i_quantValue;
    logic signed [OUT_W-1:0] o_coef;

    coef_dequant_pipe #(.COEF_W(COEF_W), .SCALE_W(SCALE_W), .QUANT_W(QUANT_W),
                        .OUT_W(OUT_W), .NUM_TABLES(NUM_TABLES)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_coef(i_coef), .i_scale(i_scale), .i_isDC(i_isDC), .i_mode(i_mode),
        .i_tblSel(i_tblSel), .i_index(i_index), .i_linearIndex(i_linearIndex),
        .i_blockNum(i_blockNum), .i_last(i_last), .i_quantWrt(i_quantWrt),
        .i_quantTbl(i_quantTbl), .i_quantAdr(i_quantAdr), .i_quantValue(i_quantValue),
        .o_valid(o_valid), .i_ready(i_ready), .o_coef(o_coef), .o_index(o_index),
        .o_blockNum(o_blockNum), .o_last(o_last));

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int tests_run = 0;
    int fails = 0;
    int tbl_m [NUM_TABLES][64];
    int ival  [NUM_TABLES][64];
    logic [21:0] sb [$];
    bit bp_en = 0;
    int hold = 0;
    bit wr_pend = 0;
    int wt, wa;
    logic [4*QUANT_W-1:0] wv;

    function automatic logic [11:0] model(int coef, int scale, bit dc, int mode, int tsel, int lin);
        longint p, t, y;
        int s, q;
        if (mode >= 2) return 12'(coef);
        if (mode == 1) begin s = 16; q = 1; end
        else begin s = dc ? 8 : scale; q = tbl_m[tsel][dc ? 0 : lin]; end
        p = longint'(coef) * s * q;
        t = p + 4;
        if (t >= 0) y = t / 8; else y = -((-t + 7) / 8);
        if (y > 2047) y = 2047;
        if (y < -2048) y = -2048;
        return 12'(y);
    endfunction

    task automatic tick_ready();
        if (bp_en) begin
            if (hold == 0) begin
                i_ready = 1'($urandom_range(0, 1));
                hold = $urandom_range(1, 10);
            end
            hold--;
        end
    endtask

    task automatic apply_wr();
        i_quantWrt = wr_pend;
        i_quantTbl = TSEL_W'(wt);
        i_quantAdr = 4'(wa);
        i_quantValue = wv;
    endtask

    task automatic commit_wr();
        if (wr_pend) begin
            for (int k = 0; k < 4; k++) tbl_m[wt][wa*4+k] = int'(wv[k*QUANT_W +: QUANT_W]);
            wr_pend = 0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge i_clk);
            i_valid = 1'b0;
            apply_wr();
            tick_ready();
            @(posedge i_clk);
            commit_wr();
        end
    endtask

    task automatic send(input int coef, input int scale, input bit dc, input int mode,
                        input int tsel, input int lin, input int idx, input int blk, input bit last);
        logic [21:0] e;
        bit acc;
        int n;
        e = {model(coef, scale, dc, mode, tsel, lin), 6'(idx), 3'(blk), last};
        acc = 0;
        n = 0;
        while (!acc && n < 200) begin
            @(negedge i_clk);
            i_valid = 1'b1; i_coef = COEF_W'(coef); i_scale = SCALE_W'(scale); i_isDC = dc;
            i_mode = 2'(mode); i_tblSel = TSEL_W'(tsel); i_linearIndex = 6'(lin);
            i_index = 6'(idx); i_blockNum = 3'(blk); i_last = last;
            apply_wr();
            tick_ready();
            #1;
            acc = o_ready;
            if (acc) sb.push_back(e);
            @(posedge i_clk);
            commit_wr();
            n++;
        end
        if (!acc) begin
            tests_run++; fails++;
            $display("FAIL accept_timeout: o_ready=%b required=1", o_ready);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 400) begin idle(1); n++; end
        idle(1);
        tests_run++;
        if (sb.size() !== 0) begin
            fails++;
            $display("FAIL drain: pending=%0d required=0", sb.size());
        end
    endtask

    // Output monitor: scoreboard compare on transfer, stability compare while stalled
    bit prev_stall = 0;
    logic [21:0] prev_out;
    always begin
        logic [21:0] e, cur;
        @(negedge i_clk);
        #2;
        cur = {o_coef, o_index, o_blockNum, o_last};
        if (i_rst) prev_stall = 0;
        else begin
            if (prev_stall && o_valid) begin
                tests_run++;
                if (cur !== prev_out) begin
                    fails++;
                    $display("FAIL stall_stable: got=%h required=%h", cur, prev_out);
                end
            end
            if (o_valid && i_ready) begin
                tests_run++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_output: got=%h required=none", cur);
                end else begin
                    e = sb.pop_front();
                    if (cur !== e) begin
                        fails++;
                        $display("FAIL output: got coef=%0d idx=%0d blk=%0d last=%b required coef=%0d idx=%0d blk=%0d last=%b",
                                 $signed(cur[21:10]), cur[9:4], cur[3:1], cur[0],
                                 $signed(e[21:10]), e[9:4], e[3:1], e[0]);
                    end
                end
            end
            prev_stall = o_valid && !i_ready;
            prev_out = cur;
        end
    end

    task automatic test_reset();
        i_rst = 1'b1; i_valid = 0; i_ready = 1; i_coef = '0; i_scale = '0; i_isDC = 0;
        i_mode = '0; i_tblSel = '0; i_index = '0; i_linearIndex = '0; i_blockNum = '0;
        i_last = 0; i_quantWrt = 0; i_quantTbl = '0; i_quantAdr = '0; i_quantValue = '0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        tests_run++;
        if ({o_valid, o_coef, o_index, o_blockNum, o_last, o_ready} !== {1'b0, 22'd0, 1'b1}) begin
            fails++;
            $display("FAIL reset_state: valid=%b coef=%0d idx=%0d blk=%0d last=%b ready=%b required 0,0,0,0,0,1",
                     o_valid, o_coef, o_index, o_blockNum, o_last, o_ready);
        end
        i_rst = 1'b0;
    endtask

    task automatic init_tables();
        for (int t = 0; t < NUM_TABLES; t++)
            for (int i = 0; i < 64; i++) ival[t][i] = ((t * 64 + i) * 37) % 127 + 1;
        ival[0][4] = 3; ival[0][5] = 16; ival[0][6] = 1; ival[0][7] = 2; ival[0][8] = 127;
        ival[1][0] = 8;
        for (int t = 0; t < NUM_TABLES; t++)
            for (int w = 0; w < 16; w++) begin
                wr_pend = 1; wt = t; wa = w;
                for (int k = 0; k < 4; k++) wv[k*QUANT_W +: QUANT_W] = QUANT_W'(ival[t][w*4+k]);
                idle(1);
            end
        idle(1);
    endtask

    task automatic test_standard();
        send(100, 10, 0, 0, 0, 5, 5, 2, 1);
        idle(1);
        #1;
        tests_run++;
        if (o_valid !== 1'b0) begin
            fails++;
            $display("FAIL latency_early: o_valid=%b required=0", o_valid);
        end
        idle(1);
        #1;
        tests_run++;
        if (o_valid !== 1'b1 || o_coef !== 12'sd2000) begin
            fails++;
            $display("FAIL latency_standard: o_valid=%b o_coef=%0d required 1, 2000", o_valid, o_coef);
        end
        drain();
    endtask

    task automatic test_rounding_clamp();
        send(-1, 1, 0, 0, 0, 6, 1, 0, 0);
        send(-5, 1, 0, 0, 0, 7, 2, 0, 0);
        send(3, 1, 0, 0, 0, 6, 3, 0, 0);
        send(511, 63, 0, 0, 0, 8, 4, 1, 0);
        send(-512, 63, 0, 0, 0, 8, 5, 1, 1);
        drain();
    endtask

    task automatic test_modes();
        send(-3, 40, 1, 0, 1, 9, 0, 3, 0);
        send(-7, 5, 0, 1, 0, 12, 10, 3, 0);
        send(-512, 7, 0, 2, 1, 13, 11, 4, 0);
        send(100, 7, 1, 3, 0, 14, 12, 4, 1);
        drain();
    endtask

    task automatic test_read_first();
        wr_pend = 1; wt = 0; wa = 1;
        for (int k = 0; k < 4; k++) wv[k*QUANT_W +: QUANT_W] = QUANT_W'(50 + k);
        send(20, 4, 0, 0, 0, 4, 20, 5, 0);
        send(20, 4, 0, 0, 0, 4, 21, 5, 1);
        drain();
    endtask

    task automatic test_back_to_back();
        bp_en = 1; hold = 0;
        for (int i = 0; i < 64; i++) begin
            send(int'($urandom_range(0, 1023)) - 512, int'($urandom_range(0, 63)),
                 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
                 int'($urandom_range(0, 63)), i, i % 8, i == 63);
            if ($urandom_range(0, 7) == 0) idle(1);
        end
        drain();
        bp_en = 0;
        i_ready = 1;
        idle(2);
    endtask

    task automatic test_reset_midstream();
        send(123, 9, 0, 0, 1, 20, 30, 6, 0);
        send(-77, 11, 0, 0, 1, 21, 31, 6, 0);
        idle(1);
        #1;
        tests_run++;
        if (o_valid !== 1'b1) begin
            fails++;
            $display("FAIL inflight_before_reset: o_valid=%b required=1", o_valid);
        end
        @(negedge i_clk);
        i_valid = 0;
        i_rst = 1;
        #1;
        sb.delete();
        tests_run++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_midstream: o_valid=%b o_ready=%b required 0, 1", o_valid, o_ready);
        end
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 0;
        send(45, 13, 0, 0, 0, 22, 40, 7, 1);
        drain();
    endtask

    initial begin
        test_reset();
        init_tables();
        test_standard();
        test_rounding_clamp();
        test_modes();
        test_read_first();
        test_back_to_back();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
